scale_apply: RTL and testbench

//   Post-scaler at the consumer end of the PE scale path. Takes the accumulated

---
 rtl/scale_apply.sv | 115 +++++++++++
 tb/tb_scale_apply.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scale_apply.sv
// Post-scaler: res = sat((acc * scale) >>> FRA_BW) over a two-stage valid/ready pipeline.
// Optional SCALE_APPLY_ROUND_EN adds round-half-up before the shift; gemm beats pass acc through.
module scale_apply #(
  parameter int unsigned INT_BW = 5,
  parameter int unsigned FRA_BW = 10,
  parameter int unsigned MUL_BW = 1 + INT_BW + FRA_BW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        gemm_uno,
  input  logic [MUL_BW-1:0] acc_i,
  input  logic [MUL_BW-1:0] scale_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [MUL_BW-1:0] res_o,
  output logic              sat_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  localparam int unsigned PROD_BW = 2 * MUL_BW;
  localparam int unsigned EXT_BW  = PROD_BW + 1;

  // Clamp limits sign-extended to the shifted-product width.
  localparam logic signed [EXT_BW-1:0] QMAX =
    $signed({{(EXT_BW - MUL_BW + 1){1'b0}}, {(MUL_BW - 1){1'b1}}});
  localparam logic signed [EXT_BW-1:0] QMIN =
    $signed({{(EXT_BW - MUL_BW + 1){1'b1}}, {(MUL_BW - 1){1'b0}}});
  localparam logic [MUL_BW-1:0] RES_MAX = {1'b0, {(MUL_BW - 1){1'b1}}};
  localparam logic [MUL_BW-1:0] RES_MIN = {1'b1, {(MUL_BW - 1){1'b0}}};

  typedef enum logic [1:0] {
    OpGemm = 2'b00,
    OpDiv  = 2'b01,
    OpExp  = 2'b10,
    OpLog  = 2'b11
  } op_e;

  logic adv1, adv2;

  // Stage 1 state
  logic                      v1_q;
  op_e                       op1_q;
  logic signed [PROD_BW-1:0] prod1_q;
  logic signed [PROD_BW-1:0] prod_d;

  // Stage 2 next-state
  logic signed [EXT_BW-1:0] pre_shift;
  logic signed [EXT_BW-1:0] q;
  logic [MUL_BW-1:0]        res_d;
  logic                     sat_d;

  assign adv2       = ~out_valid_o | out_ready_i;
  assign adv1       = ~v1_q | adv2;
  assign in_ready_o = adv1;

  // Gemm beats carry acc sign-extended in the product slot so stage 2 can pass it through.
  always_comb begin
    prod_d = $signed(acc_i) * $signed(scale_i);
    if (op_e'(gemm_uno) == OpGemm) begin
      prod_d = {{(PROD_BW - MUL_BW){acc_i[MUL_BW-1]}}, acc_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      op1_q   <= OpGemm;
      prod1_q <= '0;
    end else if (adv1) begin
      v1_q <= in_valid_i;
      if (in_valid_i) begin
        op1_q   <= op_e'(gemm_uno);
        prod1_q <= prod_d;
      end
    end
  end

  always_comb begin
`ifdef SCALE_APPLY_ROUND_EN
    pre_shift = $signed({prod1_q[PROD_BW-1], prod1_q})
              + $signed(EXT_BW'(2 ** (FRA_BW - 1)));
`else
    pre_shift = $signed({prod1_q[PROD_BW-1], prod1_q});
`endif
    q = pre_shift >>> FRA_BW;

    res_d = q[MUL_BW-1:0];
    sat_d = 1'b0;
    if (op1_q == OpGemm) begin
      res_d = prod1_q[MUL_BW-1:0];
    end else if (q > QMAX) begin
      res_d = RES_MAX;
      sat_d = 1'b1;
    end else if (q < QMIN) begin
      res_d = RES_MIN;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      res_o       <= '0;
      sat_o       <= 1'b0;
    end else if (adv2) begin
      out_valid_o <= v1_q;
      if (v1_q) begin
        res_o <= res_d;
        sat_o <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_scale_apply.sv
// Directed self-checking bench for scale_apply; expectations follow SCALE_APPLY_ROUND_EN.
module tb_scale_apply;

  logic        clk;
  logic        rst_n;
  logic [1:0]  gemm_uno;
  logic [15:0] acc_i;
  logic [15:0] scale_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] res_o;
  logic        sat_o;
  logic        out_valid_o;
  logic        out_ready_i;

  int checks = 0;
  int errors = 0;

  logic [1:0]  v_op  [16];
  logic [15:0] v_acc [16];
  logic [15:0] v_scl [16];
  logic [15:0] e_res [16];
  logic        e_sat [16];
  logic [15:0] o_res [16];
  logic        o_sat [16];
  int          acc_cnt [64];
  logic        inr_log [64];
  int          stable_err;

  scale_apply dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gemm_uno   (gemm_uno),
    .acc_i      (acc_i),
    .scale_i    (scale_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .res_o      (res_o),
    .sat_o      (sat_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_vec(input int i, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] s, input logic [15:0] r, input logic st);
    v_op[i] = op; v_acc[i] = a; v_scl[i] = s; e_res[i] = r; e_sat[i] = st;
  endtask

  // Streams n beats from the vector table; out_ready follows rdy_pat per cycle.
  task automatic run_stream(input int n, input logic [31:0] rdy_pat, input int max_cyc,
                            output int n_out, output int cycles);
    int   idx;
    logic in_hs, out_hs, held;
    logic [15:0] held_res;
    logic held_sat;
    idx = 0; n_out = 0; cycles = 0; stable_err = 0; held = 1'b0;
    held_res = '0; held_sat = 1'b0;
    for (int c = 0; c < max_cyc && n_out < n; c++) begin
      @(negedge clk);
      out_ready_i = (c < 32) ? rdy_pat[c] : 1'b1;
      if (idx < n) begin
        in_valid_i = 1'b1; gemm_uno = v_op[idx]; acc_i = v_acc[idx]; scale_i = v_scl[idx];
      end else begin
        in_valid_i = 1'b0;
      end
      #1;
      if (held && (res_o !== held_res || sat_o !== held_sat || out_valid_o !== 1'b1))
        stable_err++;
      in_hs  = in_valid_i & in_ready_o;
      out_hs = out_valid_o & out_ready_i;
      if (out_hs) begin
        o_res[n_out] = res_o; o_sat[n_out] = sat_o; n_out++;
      end
      held = out_valid_o & ~out_ready_i; held_res = res_o; held_sat = sat_o;
      inr_log[c] = in_ready_o;
      cycles = c + 1;
      @(posedge clk);
      if (in_hs) idx++;
      acc_cnt[c] = idx;
    end
    @(negedge clk);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    gemm_uno = 2'b00; acc_i = '0; scale_i = '0;
    #12;
    checks++;
    if (out_valid_o !== 1'b0 || res_o !== 16'h0000 || sat_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b res=%h sat=%b, want 0/0000/0",
               out_valid_o, res_o, sat_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready_o);
    end
  endtask

  task automatic test_arith;
    int n_out, cyc;
    set_vec(0, 2'b01, 16'h0800, 16'h0600, 16'h0C00, 1'b0);
    set_vec(1, 2'b10, 16'h7000, 16'h7000, 16'h7FFF, 1'b1);
    set_vec(2, 2'b10, 16'h9000, 16'h7000, 16'h8000, 1'b1);
    set_vec(3, 2'b11, 16'h0C00, 16'hFFFF, 16'hFFFD, 1'b0);
`ifdef SCALE_APPLY_ROUND_EN
    set_vec(4, 2'b01, 16'h0001, 16'h0200, 16'h0001, 1'b0);
    set_vec(5, 2'b01, 16'hFFFF, 16'h0200, 16'h0000, 1'b0);
`else
    set_vec(4, 2'b01, 16'h0001, 16'h0200, 16'h0000, 1'b0);
    set_vec(5, 2'b01, 16'hFFFF, 16'h0200, 16'hFFFF, 1'b0);
`endif
    set_vec(6, 2'b11, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    set_vec(7, 2'b01, 16'h0600, 16'h0300, 16'h0480, 1'b0);
    // Exactly at the limits: must not flag saturation.
    set_vec(8, 2'b01, 16'h8000, 16'h0400, 16'h8000, 1'b0);
    set_vec(9, 2'b10, 16'h7FFF, 16'h0400, 16'h7FFF, 1'b0);
    run_stream(10, 32'hFFFF_FFFF, 40, n_out, cyc);
    checks++;
    if (n_out !== 10) begin
      errors++;
      $display("FAIL arith_count: got %0d beats, want 10", n_out);
    end
    for (int i = 0; i < n_out && i < 10; i++) begin
      checks++;
      if (o_res[i] !== e_res[i] || o_sat[i] !== e_sat[i]) begin
        errors++;
        $display("FAIL arith_vec%0d: got res=%h sat=%b, want res=%h sat=%b",
                 i, o_res[i], o_sat[i], e_res[i], e_sat[i]);
      end
    end
  endtask

  task automatic test_gemm;
    int n_out, cyc;
    set_vec(0, 2'b00, 16'h8000, 16'h1234, 16'h8000, 1'b0);
    set_vec(1, 2'b00, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b0);
    set_vec(2, 2'b00, 16'h0ABC, 16'h7000, 16'h0ABC, 1'b0);
    run_stream(3, 32'hFFFF_FFFF, 20, n_out, cyc);
    checks++;
    if (n_out !== 3) begin
      errors++;
      $display("FAIL gemm_count: got %0d beats, want 3", n_out);
    end
    for (int i = 0; i < n_out && i < 3; i++) begin
      checks++;
      if (o_res[i] !== e_res[i] || o_sat[i] !== e_sat[i]) begin
        errors++;
        $display("FAIL gemm_vec%0d: got res=%h sat=%b, want res=%h sat=%b",
                 i, o_res[i], o_sat[i], e_res[i], e_sat[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n_out, cyc;
    logic all_ready;
    set_vec(0, 2'b00, 16'h0101, 16'h0000, 16'h0101, 1'b0);
    set_vec(1, 2'b01, 16'h0400, 16'h0800, 16'h0800, 1'b0);
    set_vec(2, 2'b00, 16'h0303, 16'h0000, 16'h0303, 1'b0);
    run_stream(3, 32'hFFFF_FFFF, 20, n_out, cyc);
    all_ready = 1'b1;
    for (int c = 0; c < cyc; c++) all_ready &= inr_log[c];
    checks++;
    if (n_out !== 3 || cyc !== 5 || all_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_timing: got beats=%0d cycles=%0d ready=%b, want 3/5/1",
               n_out, cyc, all_ready);
    end
    for (int i = 0; i < n_out && i < 3; i++) begin
      checks++;
      if (o_res[i] !== e_res[i]) begin
        errors++;
        $display("FAIL b2b_vec%0d: got res=%h, want %h", i, o_res[i], e_res[i]);
      end
    end
  endtask

  task automatic test_stall;
    int n_out, cyc;
    set_vec(0, 2'b00, 16'h0011, 16'h0000, 16'h0011, 1'b0);
    set_vec(1, 2'b01, 16'h0800, 16'h0800, 16'h1000, 1'b0);
    set_vec(2, 2'b00, 16'h0044, 16'h7777, 16'h0044, 1'b0);
    set_vec(3, 2'b10, 16'h0400, 16'hFC00, 16'hFC00, 1'b0);
    // out_ready low for cycles 0..5.
    run_stream(4, 32'hFFFF_FFC0, 40, n_out, cyc);
    checks++;
    if (cyc < 6 || acc_cnt[5] !== 2 || inr_log[5] !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept: got accepted=%0d in_ready=%b, want 2/0",
               acc_cnt[5], inr_log[5]);
    end
    checks++;
    if (stable_err !== 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d output changes while stalled, want 0", stable_err);
    end
    checks++;
    if (n_out !== 4) begin
      errors++;
      $display("FAIL stall_count: got %0d beats, want 4", n_out);
    end
    for (int i = 0; i < n_out && i < 4; i++) begin
      checks++;
      if (o_res[i] !== e_res[i] || o_sat[i] !== e_sat[i]) begin
        errors++;
        $display("FAIL stall_vec%0d: got res=%h sat=%b, want res=%h sat=%b",
                 i, o_res[i], o_sat[i], e_res[i], e_sat[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    int n_out, cyc;
    @(negedge clk);
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; gemm_uno = 2'b00; acc_i = 16'h5A5A; scale_i = '0;
    @(negedge clk);
    acc_i = 16'hA5A5;
    @(negedge clk);
    in_valid_i = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b1 || res_o !== 16'h5A5A) begin
      errors++;
      $display("FAIL midrst_preload: got valid=%b res=%h, want 1/5a5a", out_valid_o, res_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || res_o !== 16'h0000 || sat_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: got valid=%b res=%h sat=%b, want 0/0000/0",
               out_valid_o, res_o, sat_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    set_vec(0, 2'b00, 16'h1234, 16'h5555, 16'h1234, 1'b0);
    run_stream(1, 32'hFFFF_FFFF, 10, n_out, cyc);
    // Exactly 3 cycles proves no stale beat emerged ahead of the new one.
    checks++;
    if (n_out !== 1 || cyc !== 3 || o_res[0] !== 16'h1234 || o_sat[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_first: got beats=%0d cycles=%0d res=%h sat=%b, want 1/3/1234/0",
               n_out, cyc, o_res[0], o_sat[0]);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_gemm();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
